// File: rtl/alu_pkg.sv
// Shared definitions for the ALU checker and its golden model.
//   XLEN       : datapath width.
//   ALU_*      : ALUctl encodings understood by the RISC-V ALU.
//   status_e   : checker verdict (IDLE / PASS / FAIL).
//   alu_txn_t  : one sampled transaction as carried through the delay line.
package alu_pkg;

   localparam int XLEN = 32;

   localparam logic [3:0] ALU_AND = 4'd0;
   localparam logic [3:0] ALU_OR  = 4'd1;
   localparam logic [3:0] ALU_ADD = 4'd2;
   localparam logic [3:0] ALU_SUB = 4'd6;
   localparam logic [3:0] ALU_SLT = 4'd7;
   localparam logic [3:0] ALU_NOR = 4'd12;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PASS = 2'd1,
      ST_FAIL = 2'd2
   } status_e;

   typedef struct packed {
      logic            vld;
      logic [3:0]      ctl;
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
   } alu_txn_t;

endpackage

// File: rtl/alu_golden.sv
// Purely combinational golden model of the RISC-V ALU.
//   ctl       : ALUctl code
//   a, b      : operands
//   expected  : reference result (0 when ctl is unsupported)
//   supported : 1 when ctl is one of the known ALU operations
module alu_golden
   import alu_pkg::*;
(
   input  logic [3:0]      ctl,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic [XLEN-1:0] expected,
   output logic            supported
);

   // Reference result per ALUctl; anything unknown is flagged unsupported.
   always_comb begin
      expected  = '0;
      supported = 1'b1;
      case (ctl)
         ALU_AND: expected = a & b;
         ALU_OR:  expected = a | b;
         ALU_ADD: expected = a + b;
         ALU_SUB: expected = a - b;
         ALU_SLT: expected = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
         ALU_NOR: expected = ~(a | b);
         default: begin
            expected  = '0;
            supported = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/riscv_alu_checker.sv
// Self-checking monitor for the RISC-V ALU.
// Samples alu_ctl/a/b when sample_en is high, delays them LATENCY cycles to
// line up with alu_out, compares against alu_golden and keeps saturating
// pass/fail/unsupported counters, a sticky verdict and the first mismatch.
//   clk, reset      : clock, synchronous active-high reset
//   sample_en       : operands valid this cycle
//   clear           : synchronous soft clear of everything (drops that cycle's sample/compare)
//   alu_ctl, a, b   : ALU inputs being snooped
//   alu_out         : ALU result being snooped
//   pass_cnt/fail_cnt/unsup_cnt : saturating event counters
//   status          : 0=IDLE, 1=PASS, 2=FAIL
//   err_*           : transaction of the first mismatch
module riscv_alu_checker
   import alu_pkg::*;
#(
   parameter int LATENCY = 0,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sample_en,
   input  logic             clear,
   input  logic [3:0]       alu_ctl,
   input  logic [XLEN-1:0]  a,
   input  logic [XLEN-1:0]  b,
   input  logic [XLEN-1:0]  alu_out,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] fail_cnt,
   output logic [CNT_W-1:0] unsup_cnt,
   output logic [1:0]       status,
   output logic [3:0]       err_ctl,
   output logic [XLEN-1:0]  err_a,
   output logic [XLEN-1:0]  err_b,
   output logic [XLEN-1:0]  err_got,
   output logic [XLEN-1:0]  err_exp
);

   alu_txn_t        cmp_s;     // transaction whose result is on alu_out now
   logic [XLEN-1:0] exp_s;
   logic            sup_s;

   generate
      if (LATENCY == 0) begin : g_comb
         // Combinational ALU: compare the operands of this very cycle.
         assign cmp_s = {sample_en, alu_ctl, a, b};
      end else begin : g_pipe
         alu_txn_t pipe_d [LATENCY];
         alu_txn_t pipe_q [LATENCY];

         // Shift the sampled transaction one stage per clock; bubbles carry vld=0.
         always_comb begin
            pipe_d[0] = {sample_en, alu_ctl, a, b};
            for (int i = 1; i < LATENCY; i++) begin
               pipe_d[i] = pipe_q[i-1];
            end
         end

         // Delay line register; reset/clear drop every in-flight entry.
         always_ff @(posedge clk) begin
            if (reset || clear) begin
               for (int i = 0; i < LATENCY; i++) begin
                  pipe_q[i] <= '0;
               end
            end else begin
               pipe_q <= pipe_d;
            end
         end

         assign cmp_s = pipe_q[LATENCY-1];
      end
   endgenerate

   alu_golden u_golden (
      .ctl       (cmp_s.ctl),
      .a         (cmp_s.a),
      .b         (cmp_s.b),
      .expected  (exp_s),
      .supported (sup_s)
   );

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   logic            do_cmp_s;
   logic            match_s;
   logic            unsup_evt_s;

   status_e          status_d,    status_q;
   logic [CNT_W-1:0] pass_cnt_d,  pass_cnt_q;
   logic [CNT_W-1:0] fail_cnt_d,  fail_cnt_q;
   logic [CNT_W-1:0] unsup_cnt_d, unsup_cnt_q;
   logic [3:0]       err_ctl_d,   err_ctl_q;
   logic [XLEN-1:0]  err_a_d,     err_a_q;
   logic [XLEN-1:0]  err_b_d,     err_b_q;
   logic [XLEN-1:0]  err_got_d,   err_got_q;
   logic [XLEN-1:0]  err_exp_d,   err_exp_q;

   assign do_cmp_s    = cmp_s.vld & sup_s;
   assign unsup_evt_s = cmp_s.vld & ~sup_s;
   assign match_s     = (alu_out == exp_s);

   // Verdict FSM, counters and first-mismatch capture (next-state logic).
   always_comb begin
      status_d    = status_q;
      pass_cnt_d  = pass_cnt_q;
      fail_cnt_d  = fail_cnt_q;
      unsup_cnt_d = unsup_cnt_q;
      err_ctl_d   = err_ctl_q;
      err_a_d     = err_a_q;
      err_b_d     = err_b_q;
      err_got_d   = err_got_q;
      err_exp_d   = err_exp_q;

      if (unsup_evt_s) begin
         unsup_cnt_d = sat_inc(unsup_cnt_q);
      end else begin
         unsup_cnt_d = unsup_cnt_q;
      end

      if (do_cmp_s && match_s) begin
         pass_cnt_d = sat_inc(pass_cnt_q);
      end else if (do_cmp_s) begin
         fail_cnt_d = sat_inc(fail_cnt_q);
      end else begin
         pass_cnt_d = pass_cnt_q;
      end

      case (status_q)
         ST_IDLE, ST_PASS: begin
            if (do_cmp_s && !match_s) begin
               // Only the first mismatch is recorded; FAIL is sticky afterwards.
               status_d  = ST_FAIL;
               err_ctl_d = cmp_s.ctl;
               err_a_d   = cmp_s.a;
               err_b_d   = cmp_s.b;
               err_got_d = alu_out;
               err_exp_d = exp_s;
            end else if (do_cmp_s) begin
               status_d = ST_PASS;
            end else begin
               status_d = status_q;
            end
         end
         ST_FAIL: status_d = ST_FAIL;
         default: status_d = ST_IDLE;
      endcase
   end

   // State/counter/capture registers with reset and soft clear.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         status_q    <= ST_IDLE;
         pass_cnt_q  <= '0;
         fail_cnt_q  <= '0;
         unsup_cnt_q <= '0;
         err_ctl_q   <= '0;
         err_a_q     <= '0;
         err_b_q     <= '0;
         err_got_q   <= '0;
         err_exp_q   <= '0;
      end else begin
         status_q    <= status_d;
         pass_cnt_q  <= pass_cnt_d;
         fail_cnt_q  <= fail_cnt_d;
         unsup_cnt_q <= unsup_cnt_d;
         err_ctl_q   <= err_ctl_d;
         err_a_q     <= err_a_d;
         err_b_q     <= err_b_d;
         err_got_q   <= err_got_d;
         err_exp_q   <= err_exp_d;
      end
   end

   assign status    = status_q;
   assign pass_cnt  = pass_cnt_q;
   assign fail_cnt  = fail_cnt_q;
   assign unsup_cnt = unsup_cnt_q;
   assign err_ctl   = err_ctl_q;
   assign err_a     = err_a_q;
   assign err_b     = err_b_q;
   assign err_got   = err_got_q;
   assign err_exp   = err_exp_q;

endmodule

// File: tb/tb_riscv_alu_checker.sv
// Bench for riscv_alu_checker: three instances (LATENCY 0/CNT_W 16,
// LATENCY 2/CNT_W 16, LATENCY 3/CNT_W 4) compared every cycle against a
// transaction-level model, plus literal expectations for the directed cases.
module tb_riscv_alu_checker;

   logic        clk = 1'b0;
   logic        reset;
   logic        se  [3];
   logic        clr [3];
   logic [3:0]  ctl [3];
   logic [31:0] a   [3];
   logic [31:0] b   [3];
   logic [31:0] ao  [3];

   logic [31:0] d_pass [3];
   logic [31:0] d_fail [3];
   logic [31:0] d_unsup[3];
   logic [31:0] d_stat [3];
   logic [31:0] d_ectl [3];
   logic [31:0] d_ea   [3];
   logic [31:0] d_eb   [3];
   logic [31:0] d_egot [3];
   logic [31:0] d_eexp [3];

   always #5 clk = ~clk;

   function automatic int lat_of(input int ch);
      return (ch == 0) ? 0 : (ch == 1) ? 2 : 3;
   endfunction

   function automatic int max_of(input int ch);
      return (ch == 2) ? 15 : 65535;
   endfunction

   genvar g;
   generate
      for (g = 0; g < 3; g++) begin : g_dut
         localparam int L = (g == 0) ? 0 : (g == 1) ? 2 : 3;
         localparam int W = (g == 2) ? 4 : 16;
         logic [W-1:0] pc, fc, uc;
         logic [1:0]   st;
         logic [3:0]   ec;
         logic [31:0]  ea, eb, eg, ee;
         riscv_alu_checker #(.LATENCY(L), .CNT_W(W)) u_dut (
            .clk(clk), .reset(reset), .sample_en(se[g]), .clear(clr[g]),
            .alu_ctl(ctl[g]), .a(a[g]), .b(b[g]), .alu_out(ao[g]),
            .pass_cnt(pc), .fail_cnt(fc), .unsup_cnt(uc), .status(st),
            .err_ctl(ec), .err_a(ea), .err_b(eb), .err_got(eg), .err_exp(ee)
         );
         assign d_pass[g]  = 32'(pc);
         assign d_fail[g]  = 32'(fc);
         assign d_unsup[g] = 32'(uc);
         assign d_stat[g]  = 32'(st);
         assign d_ectl[g]  = 32'(ec);
         assign d_ea[g]    = ea;
         assign d_eb[g]    = eb;
         assign d_egot[g]  = eg;
         assign d_eexp[g]  = ee;
      end
   endgenerate

   // ---------------- reference model ----------------
   function automatic logic is_sup(input logic [3:0] c);
      return (c == 4'd0) || (c == 4'd1) || (c == 4'd2) || (c == 4'd6) ||
             (c == 4'd7) || (c == 4'd12);
   endfunction

   function automatic logic [31:0] gold(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
      case (c)
         4'd0:    return x & y;
         4'd1:    return x | y;
         4'd2:    return x + y;
         4'd6:    return x - y;
         4'd7:    return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
         4'd12:   return ~(x | y);
         default: return 32'd0;
      endcase
   endfunction

   // In-flight transactions indexed by the cycle in which their result is due.
   logic        sv  [3][8];
   logic [3:0]  sc  [3][8];
   logic [31:0] sa  [3][8];
   logic [31:0] sb  [3][8];
   int          cyc = 0;

   int          m_pass[3], m_fail[3], m_unsup[3], m_stat[3];
   logic [31:0] m_ectl[3], m_ea[3], m_eb[3], m_egot[3], m_eexp[3];

   int errors = 0;
   int checks = 0;

   initial begin
      forever begin
         @(posedge clk);
         for (int ch = 0; ch < 3; ch++) begin
            if (reset || clr[ch]) begin
               m_pass[ch] = 0; m_fail[ch] = 0; m_unsup[ch] = 0; m_stat[ch] = 0;
               m_ectl[ch] = 0; m_ea[ch] = 0; m_eb[ch] = 0; m_egot[ch] = 0; m_eexp[ch] = 0;
               for (int k = 0; k < 8; k++) sv[ch][k] = 1'b0;
            end else begin
               int due;
               int now;
               due = (cyc + lat_of(ch)) % 8;
               now = cyc % 8;
               if (se[ch]) begin
                  sv[ch][due] = 1'b1; sc[ch][due] = ctl[ch];
                  sa[ch][due] = a[ch]; sb[ch][due] = b[ch];
               end
               if (sv[ch][now]) begin
                  logic [31:0] e;
                  sv[ch][now] = 1'b0;
                  e = gold(sc[ch][now], sa[ch][now], sb[ch][now]);
                  if (!is_sup(sc[ch][now])) begin
                     if (m_unsup[ch] < max_of(ch)) m_unsup[ch]++;
                  end else if (ao[ch] == e) begin
                     if (m_pass[ch] < max_of(ch)) m_pass[ch]++;
                     if (m_stat[ch] != 2) m_stat[ch] = 1;
                  end else begin
                     if (m_fail[ch] < max_of(ch)) m_fail[ch]++;
                     if (m_stat[ch] != 2) begin
                        m_stat[ch] = 2;
                        m_ectl[ch] = 32'(sc[ch][now]); m_ea[ch] = sa[ch][now];
                        m_eb[ch] = sb[ch][now]; m_egot[ch] = ao[ch]; m_eexp[ch] = e;
                     end
                  end
               end
            end
         end
         cyc++;
      end
   end

   task automatic chk(input string nm, input int ch, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s ch%0d got=%h expected=%h (t=%0t)", nm, ch, got, exp, $time);
      end
   endtask

   // Compare every DUT output with the model on each falling edge.
   initial begin
      forever begin
         @(negedge clk);
         for (int ch = 0; ch < 3; ch++) begin
            chk("pass_cnt",  ch, d_pass[ch],  32'(m_pass[ch]));
            chk("fail_cnt",  ch, d_fail[ch],  32'(m_fail[ch]));
            chk("unsup_cnt", ch, d_unsup[ch], 32'(m_unsup[ch]));
            chk("status",    ch, d_stat[ch],  32'(m_stat[ch]));
            chk("err_ctl",   ch, d_ectl[ch],  m_ectl[ch]);
            chk("err_a",     ch, d_ea[ch],    m_ea[ch]);
            chk("err_b",     ch, d_eb[ch],    m_eb[ch]);
            chk("err_got",   ch, d_egot[ch],  m_egot[ch]);
            chk("err_exp",   ch, d_eexp[ch],  m_eexp[ch]);
         end
      end
   end

   // ---------------- stimulus ----------------
   logic auto_out[3];
   logic cor_en;

   // Behave like an ALU with the right latency: drive the result of the
   // transaction due at the coming edge, occasionally corrupted.
   task automatic drive_alu();
      for (int ch = 0; ch < 3; ch++) begin
         if (auto_out[ch]) begin
            logic        v;
            logic [3:0]  c;
            logic [31:0] x, y, o;
            if (lat_of(ch) == 0) begin
               v = se[ch]; c = ctl[ch]; x = a[ch]; y = b[ch];
            end else begin
               v = sv[ch][cyc % 8]; c = sc[ch][cyc % 8];
               x = sa[ch][cyc % 8]; y = sb[ch][cyc % 8];
            end
            o = v ? gold(c, x, y) : $urandom;
            if (v && cor_en && ($urandom_range(0, 7) == 0)) o = o ^ (32'd1 << $urandom_range(0, 31));
            ao[ch] = o;
         end
      end
   endtask

   task automatic step();
      drive_alu();
      @(negedge clk);
      #1;
   endtask

   task automatic samp0(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y, input logic [31:0] o);
      se[0] = 1'b1; ctl[0] = c; a[0] = x; b[0] = y; ao[0] = o;
      step();
      se[0] = 1'b0;
   endtask

   function automatic logic [31:0] rnd_op();
      logic [31:0] edge_v [4];
      edge_v[0] = 32'h0000_0000; edge_v[1] = 32'hFFFF_FFFF;
      edge_v[2] = 32'h8000_0000; edge_v[3] = 32'h7FFF_FFFF;
      return ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 3)] : $urandom;
   endfunction

   logic [3:0]  ops  [6];
   logic [31:0] exps [6];

   initial begin
      ops[0] = 4'd0; ops[1] = 4'd1; ops[2] = 4'd2; ops[3] = 4'd6; ops[4] = 4'd7; ops[5] = 4'd12;
      exps[0] = 32'd5; exps[1] = 32'd5; exps[2] = 32'd10; exps[3] = 32'd0; exps[4] = 32'd0;
      exps[5] = 32'hFFFF_FFFA;
      reset = 1'b1; cor_en = 1'b0;
      for (int ch = 0; ch < 3; ch++) begin
         se[ch] = 1'b0; clr[ch] = 1'b0; ctl[ch] = 4'd0; a[ch] = 32'd0; b[ch] = 32'd0; ao[ch] = 32'd0;
         auto_out[ch] = (ch != 0);
      end
      repeat (3) step();
      chk("rst_pass",   0, d_pass[0], 32'd0);
      chk("rst_status", 1, d_stat[1], 32'd0);
      chk("rst_errgot", 2, d_egot[2], 32'd0);
      reset = 1'b0;
      step();

      // LATENCY 0: all six ops on a=5, b=5 with a correct ALU
      for (int i = 0; i < 6; i++) samp0(ops[i], 32'd5, 32'd5, exps[i]);
      chk("l0_pass6",  0, d_pass[0], 32'd6);
      chk("l0_fail0",  0, d_fail[0], 32'd0);
      chk("l0_status", 0, d_stat[0], 32'd1);
      samp0(4'd7, 32'hFFFF_FFFF, 32'd1, 32'd1);
      samp0(4'd2, 32'hFFFF_FFFF, 32'd1, 32'd0);
      chk("l0_slt_wrap", 0, d_pass[0], 32'd8);
      samp0(4'd2, 32'd5, 32'd5, 32'd9);
      chk("inj_fail",   0, d_fail[0], 32'd1);
      chk("inj_status", 0, d_stat[0], 32'd2);
      chk("inj_ctl",    0, d_ectl[0], 32'd2);
      chk("inj_got",    0, d_egot[0], 32'd9);
      chk("inj_exp",    0, d_eexp[0], 32'd10);
      samp0(4'd2, 32'd5, 32'd5, 32'd3);
      chk("inj2_fail", 0, d_fail[0], 32'd2);
      chk("inj2_got",  0, d_egot[0], 32'd9);
      samp0(4'd3, 32'd5, 32'd5, 32'd0);
      chk("unsup_cnt",  0, d_unsup[0], 32'd1);
      chk("unsup_pass", 0, d_pass[0],  32'd8);
      chk("unsup_stat", 0, d_stat[0],  32'd2);

      // LATENCY 2: four back-to-back samples then a bubble
      for (int i = 0; i < 4; i++) begin
         se[1] = 1'b1; ctl[1] = ops[i]; a[1] = rnd_op(); b[1] = rnd_op();
         step();
      end
      se[1] = 1'b0;
      step();
      chk("l2_pass3", 1, d_pass[1], 32'd3);
      step();
      chk("l2_pass4", 1, d_pass[1], 32'd4);
      step();
      chk("l2_bubble", 1, d_pass[1], 32'd4);
      chk("l2_status", 1, d_stat[1], 32'd1);

      // CNT_W 4: 20 passes saturate at 15, then clear with a sample
      for (int i = 0; i < 20; i++) begin
         se[2] = 1'b1; ctl[2] = ops[$urandom_range(0, 5)]; a[2] = rnd_op(); b[2] = rnd_op();
         step();
      end
      se[2] = 1'b0;
      repeat (4) step();
      chk("sat_pass", 2, d_pass[2], 32'd15);
      clr[2] = 1'b1; se[2] = 1'b1; ctl[2] = 4'd2; a[2] = 32'd1; b[2] = 32'd1;
      step();
      clr[2] = 1'b0; se[2] = 1'b0;
      chk("clr_pass", 2, d_pass[2], 32'd0);
      chk("clr_stat", 2, d_stat[2], 32'd0);
      repeat (5) step();
      chk("clr_nocount", 2, d_pass[2], 32'd0);

      // Randomized traffic on all three instances
      auto_out[0] = 1'b1; cor_en = 1'b1;
      for (int n = 0; n < 3000; n++) begin
         for (int ch = 0; ch < 3; ch++) begin
            se[ch]  = ($urandom_range(0, 3) != 0);
            ctl[ch] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : ops[$urandom_range(0, 5)];
            a[ch]   = rnd_op();
            b[ch]   = rnd_op();
            clr[ch] = ($urandom_range(0, 63) == 0);
         end
         reset = ($urandom_range(0, 399) == 0);
         step();
      end
      reset = 1'b0;
      for (int ch = 0; ch < 3; ch++) begin
         se[ch] = 1'b0; clr[ch] = 1'b0;
      end
      repeat (6) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
